// File: rtl/b_resolve_queue.sv
// rtl/b_resolve_queue.sv - in-order B-branch resolve queue with mispredict recovery tuple
// Optional PC check on resolve: define B_RESOLVE_QUEUE_PC_CHECK_EN.
module b_resolve_queue #(
    parameter int DEPTH = 16,
    parameter int PC_W  = 32,
    parameter int SLOTS = 4
) (
    input  logic                  fire,
    input  logic                  rst,
    input  logic [SLOTS-1:0]      i_pushValid_4,
    input  logic [SLOTS-1:0]      i_pushTaken_4,
    input  logic [SLOTS*PC_W-1:0] i_pushPc_128,
    output logic                  o_pushReady,
    input  logic                  i_resolveValid,
    input  logic                  i_resolveTaken,
    input  logic [PC_W-1:0]       i_resolvePc_32,
    output logic [7:0]            o_pendingB_8,
    output logic                  o_mispredict,
    output logic [7:0]            o_recoverPendingB_8,
    output logic                  o_correctTaken,
    output logic                  o_error
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic          mispredict_q, mispredict_d;
    logic [7:0]    recover_q, recover_d;
    logic          correct_q, correct_d;
    logic          error_q, error_d;
    logic          taken_mem_q [DEPTH];

    logic [AW:0]   count;
    logic [AW:0]   push_cnt;
    logic [AW:0]   slot_ofs [SLOTS];
    logic [AW-1:0] wr_idx [SLOTS];
    logic [AW-1:0] head_idx;
    logic          res_act, res_mis, overflow, do_push, empty_res, pc_err;

    assign count       = wr_q - rd_q;
    assign head_idx    = rd_q[AW-1:0];
    assign o_pushReady = (count <= (AW+1)'(DEPTH - SLOTS));

    // Valid slots are packed in slot order: each one lands after the valid slots before it.
    always_comb begin
        push_cnt = '0;
        for (int k = 0; k < SLOTS; k++) begin
            slot_ofs[k] = push_cnt;
            wr_idx[k]   = wr_q[AW-1:0] + push_cnt[AW-1:0];
            if (i_pushValid_4[k]) begin
                push_cnt = push_cnt + (AW+1)'(1);
            end
        end
    end

    assign res_act   = i_resolveValid && (count != '0);
    assign res_mis   = res_act && (taken_mem_q[head_idx] != i_resolveTaken);
    assign empty_res = i_resolveValid && (count == '0);
    assign overflow  = (|i_pushValid_4) && !o_pushReady;
    // A mispredict in the same cycle makes the incoming group wrong-path.
    assign do_push   = o_pushReady && !res_mis;

`ifdef B_RESOLVE_QUEUE_PC_CHECK_EN
    logic [PC_W-1:0] pc_mem_q [DEPTH];

    assign pc_err = res_act && (i_resolvePc_32 != pc_mem_q[head_idx]);

    always_ff @(posedge fire) begin
        if (do_push) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (i_pushValid_4[k]) begin
                    pc_mem_q[wr_idx[k]] <= i_pushPc_128[k*PC_W +: PC_W];
                end
            end
        end
    end
`else
    logic unused_pc;

    assign unused_pc = ^{i_pushPc_128, i_resolvePc_32};
    assign pc_err    = 1'b0;
`endif

    always_ff @(posedge fire) begin
        if (do_push) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (i_pushValid_4[k]) begin
                    taken_mem_q[wr_idx[k]] <= i_pushTaken_4[k];
                end
            end
        end
    end

    always_comb begin
        wr_d         = wr_q;
        rd_d         = rd_q;
        mispredict_d = res_mis;
        recover_d    = recover_q;
        correct_d    = correct_q;
        error_d      = error_q | overflow | empty_res | pc_err;
        if (do_push) begin
            wr_d = wr_q + push_cnt;
        end
        if (res_mis) begin
            rd_d      = wr_q;
            recover_d = 8'(count);
            correct_d = i_resolveTaken;
        end else if (res_act) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge fire or negedge rst) begin
        if (!rst) begin
            wr_q         <= '0;
            rd_q         <= '0;
            mispredict_q <= 1'b0;
            recover_q    <= '0;
            correct_q    <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            mispredict_q <= mispredict_d;
            recover_q    <= recover_d;
            correct_q    <= correct_d;
            error_q      <= error_d;
        end
    end

    assign o_pendingB_8        = 8'(count);
    assign o_mispredict        = mispredict_q;
    assign o_recoverPendingB_8 = recover_q;
    assign o_correctTaken      = correct_q;
    assign o_error             = error_q;
endmodule

// File: tb/tb_b_resolve_queue.sv
// tb/tb_b_resolve_queue.sv - directed vector bench for b_resolve_queue
module tb_b_resolve_queue;
    localparam int DEPTH = 16;
    localparam int PC_W  = 32;
    localparam int SLOTS = 4;

    logic                  fire = 1'b0;
    logic                  rst  = 1'b0;
    logic [SLOTS-1:0]      push_valid = '0;
    logic [SLOTS-1:0]      push_taken = '0;
    logic [SLOTS*PC_W-1:0] push_pc    = '0;
    logic                  push_ready;
    logic                  res_valid = 1'b0;
    logic                  res_taken = 1'b0;
    logic [PC_W-1:0]       res_pc    = '0;
    logic [7:0]            pending;
    logic                  mispredict;
    logic [7:0]            recover;
    logic                  correct;
    logic                  error;

    b_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .SLOTS(SLOTS)) dut (
        .fire                (fire),
        .rst                 (rst),
        .i_pushValid_4       (push_valid),
        .i_pushTaken_4       (push_taken),
        .i_pushPc_128        (push_pc),
        .o_pushReady         (push_ready),
        .i_resolveValid      (res_valid),
        .i_resolveTaken      (res_taken),
        .i_resolvePc_32      (res_pc),
        .o_pendingB_8        (pending),
        .o_mispredict        (mispredict),
        .o_recoverPendingB_8 (recover),
        .o_correctTaken      (correct),
        .o_error             (error)
    );

    always #5 fire = ~fire;

    typedef struct {
        logic [3:0] pv;
        logic [3:0] pt;
        logic       rv;
        logic       rt;
        int         pend;
        logic       mis;
        int         rec;
        logic       cor;
        logic       err;
        logic       rdy;
    } vec_t;

    vec_t tbl [11];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge fire);
        #1;
        push_valid = '0;
        push_taken = '0;
        push_pc    = '0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        res_pc     = '0;
    endtask

    task automatic drive(input logic [3:0] pv, input logic [3:0] pt, input logic rv, input logic rt);
        push_valid = pv;
        push_taken = pt;
        res_valid  = rv;
        res_taken  = rt;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    logic        q_t  [$];
    logic [31:0] q_pc [$];
    logic [31:0] pc_ctr;
    logic        exp_cor;
    int          exp_rec;

    initial begin
        //            pv       pt       rv    rt    pend mis   rec cor   err   rdy
        tbl[0]  = '{4'b1011, 4'b0010, 1'b0, 1'b0, 3, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{4'b0111, 4'b0101, 1'b0, 1'b0, 3, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{4'b0011, 4'b0000, 1'b1, 1'b0, 0, 1'b1, 3, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{4'b1111, 4'b0000, 1'b0, 1'b0, 4, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 4, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 0, 1'b1, 4, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1};

        #12;
        chk("reset_pending", 32'(pending), 0);
        chk("reset_ready", 32'(push_ready), 1);
        chk("reset_mispredict", 32'(mispredict), 0);
        chk("reset_recover", 32'(recover), 0);
        chk("reset_correct", 32'(correct), 0);
        chk("reset_error", 32'(error), 0);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].pv, tbl[i].pt, tbl[i].rv, tbl[i].rt);
            chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
            chk($sformatf("vec%0d_mispredict", i), 32'(mispredict), 32'(tbl[i].mis));
            chk($sformatf("vec%0d_error", i), 32'(error), 32'(tbl[i].err));
            chk($sformatf("vec%0d_ready", i), 32'(push_ready), 32'(tbl[i].rdy));
            if (tbl[i].mis) begin
                chk($sformatf("vec%0d_recover", i), 32'(recover), 32'(tbl[i].rec));
                chk($sformatf("vec%0d_correct", i), 32'(correct), 32'(tbl[i].cor));
            end
        end

        // Fill to DEPTH-3 and overflow
        do_reset();
        for (int i = 0; i < 3; i++) drive(4'b1111, 4'b0000, 1'b0, 1'b0);
        chk("fill12_pending", 32'(pending), 12);
        chk("fill12_ready", 32'(push_ready), 1);
        drive(4'b0001, 4'b0000, 1'b0, 1'b0);
        chk("fill13_pending", 32'(pending), 13);
        chk("fill13_ready", 32'(push_ready), 0);
        chk("fill13_error", 32'(error), 0);
        drive(4'b0001, 4'b0000, 1'b0, 1'b0);
        chk("overflow_error", 32'(error), 1);
        chk("overflow_pending", 32'(pending), 13);

        // Empty resolve after reset
        do_reset();
        drive(4'b0000, 4'b0000, 1'b1, 1'b0);
        chk("empty_res_error", 32'(error), 1);
        chk("empty_res_pending", 32'(pending), 0);
        drive(4'b0001, 4'b0001, 1'b0, 1'b0);
        chk("after_empty_push", 32'(pending), 1);
        drive(4'b0000, 4'b0000, 1'b1, 1'b1);
        chk("after_empty_pop", 32'(pending), 0);
        chk("after_empty_mis", 32'(mispredict), 0);

        // Long wrapping run with matching directions and PCs
        do_reset();
        pc_ctr = 32'h100;
        for (int i = 0; i < 40; i++) begin
            push_valid = (i % 5 == 0) ? 4'b0011 : 4'b0001;
            push_taken = 4'($urandom_range(0, 15));
            push_pc[31:0]  = pc_ctr;
            push_pc[63:32] = pc_ctr + 32'd1;
            res_valid = (q_t.size() > 0);
            if (res_valid) begin
                res_taken = q_t[0];
                res_pc    = q_pc[0];
                void'(q_t.pop_front());
                void'(q_pc.pop_front());
            end
            q_t.push_back(push_taken[0]);
            q_pc.push_back(pc_ctr);
            if (push_valid[1]) begin
                q_t.push_back(push_taken[1]);
                q_pc.push_back(pc_ctr + 32'd1);
            end
            pc_ctr = pc_ctr + 32'd2;
            tick();
            chk($sformatf("wrap%0d_pending", i), 32'(pending), 32'(q_t.size()));
            chk($sformatf("wrap%0d_mispredict", i), 32'(mispredict), 0);
        end

        // Correct direction, wrong PC
        res_valid = 1'b1;
        res_taken = q_t[0];
        res_pc    = q_pc[0] ^ 32'd1;
        void'(q_t.pop_front());
        void'(q_pc.pop_front());
        tick();
        chk("pcchk_pending", 32'(pending), 32'(q_t.size()));
        chk("pcchk_mispredict", 32'(mispredict), 0);
`ifdef B_RESOLVE_QUEUE_PC_CHECK_EN
        chk("pcchk_error", 32'(error), 1);
`else
        chk("pcchk_error", 32'(error), 0);
`endif

        // Mispredict, then asynchronous reset between edges
        exp_rec   = q_t.size();
        exp_cor   = ~q_t[0];
        res_valid = 1'b1;
        res_taken = exp_cor;
        res_pc    = q_pc[0];
        tick();
        chk("late_mis", 32'(mispredict), 1);
        chk("late_recover", 32'(recover), 32'(exp_rec));
        chk("late_correct", 32'(correct), 32'(exp_cor));
        chk("late_pending", 32'(pending), 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_pending", 32'(pending), 0);
        chk("async_rst_mis", 32'(mispredict), 0);
        chk("async_rst_recover", 32'(recover), 0);
        chk("async_rst_correct", 32'(correct), 0);
        chk("async_rst_error", 32'(error), 0);
        chk("async_rst_ready", 32'(push_ready), 1);
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
